frame_bbox_stats: RTL and testbench

Streaming per-frame region statistics for the camera pipeline. The block sits on the grayscale pixel stream at the pixel clock, ahead of or in parallel with the frame buffer. It classifies each pixel as dark against a runtime threshold and tracks the dark-region bounding box (XSTART/XEND/YSTART/YEND) and the dark-pixel count. At each frame end it latches the results for the crop and sound/display logic. Frame geometry, data width and counter widths are parametrised, and capture is gated by an enable that is frame-aligned.

---
 rtl/frame_bbox_stats_pkg.sv | 43 ++++
 rtl/frame_bbox_stats_minmax.sv | 42 ++++
 rtl/frame_bbox_stats.sv | 207 ++++++++++++++++++++
 tb/tb_frame_bbox_stats.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_bbox_stats_pkg.sv
// frame_bbox_pkg: shared types, constants and helpers for frame_bbox_stats.
// The margin helpers are only used when FBS_MARGIN_EN is defined.
`timescale 1ns/1ps
package frame_bbox_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        ACQ      = 2'd2
    } fbs_state_t;

    localparam int COORD_W = 16;

    typedef struct packed {
        logic [COORD_W-1:0] xs;
        logic [COORD_W-1:0] xe;
        logic [COORD_W-1:0] ys;
        logic [COORD_W-1:0] ye;
    } fbs_box_t;

    // Width of the x/y position counters: enough bits for the larger axis.
    function automatic int fbs_pos_w(input int h, input int v);
        int m;
        m = (h > v) ? h : v;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Move a low box edge outwards by m, stopping at 0.
    function automatic logic [COORD_W-1:0] fbs_expand_lo(input logic [COORD_W-1:0] v,
                                                         input logic [7:0] m);
        return (v > COORD_W'(m)) ? v - COORD_W'(m) : '0;
    endfunction

    // Move a high box edge outwards by m, stopping at lim.
    function automatic logic [COORD_W-1:0] fbs_expand_hi(input logic [COORD_W-1:0] v,
                                                         input logic [7:0] m,
                                                         input logic [COORD_W-1:0] lim);
        logic [COORD_W:0] s;
        s = {1'b0, v} + {{(COORD_W-7){1'b0}}, m};
        return (s > {1'b0, lim}) ? lim : s[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/frame_bbox_stats_minmax.sv
// fbs_minmax: running min/max tracker for one coordinate axis.
// The *_nxt outputs already include the current sample, so the owner can
// latch a result that contains the pixel being accepted this cycle.
`timescale 1ns/1ps
module fbs_minmax #(
    parameter int           W        = 10,
    parameter logic [W-1:0] INIT_MIN = '1,
    parameter logic [W-1:0] INIT_MAX = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         update,
    input  logic [W-1:0] value,
    output logic [W-1:0] min_nxt,
    output logic [W-1:0] max_nxt
);

    logic [W-1:0] min_q;
    logic [W-1:0] max_q;

    // Candidate extremes with the current sample folded in.
    always_comb begin
        min_nxt = (update && (value < min_q)) ? value : min_q;
        max_nxt = (update && (value > max_q)) ? value : max_q;
    end

    // Init wins over update: the frame-end sample is consumed via *_nxt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q <= INIT_MIN;
            max_q <= INIT_MAX;
        end else if (init) begin
            min_q <= INIT_MIN;
            max_q <= INIT_MAX;
        end else begin
            min_q <= min_nxt;
            max_q <= max_nxt;
        end
    end

endmodule

// File: rtl/frame_bbox_stats.sv
// frame_bbox_stats: per-frame dark-region bounding box and dark-pixel count.
// Optional feature: define FBS_MARGIN_EN to expand the latched box by iMARGIN
// (clamped to the frame) at the cost of one extra output cycle.
`timescale 1ns/1ps
module frame_bbox_stats
    import frame_bbox_pkg::*;
#(
    parameter int DW        = 12,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int CW        = 20,
    parameter int MIN_COUNT = 16
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iEN,
    input  logic               iDVAL,
    input  logic [DW-1:0]      iDATA,
    input  logic [DW-1:0]      iTHRESH,
    input  logic               iRESYNC,
`ifdef FBS_MARGIN_EN
    input  logic [7:0]         iMARGIN,
`endif
    output logic [COORD_W-1:0] oXSTART,
    output logic [COORD_W-1:0] oXEND,
    output logic [COORD_W-1:0] oYSTART,
    output logic [COORD_W-1:0] oYEND,
    output logic [CW-1:0]      oDARK_CNT,
    output logic               oBOX_VALID,
    output logic               oFRAME_DONE,
    output logic               oBUSY
);

    localparam int            PW      = fbs_pos_w(H_ACTIVE, V_ACTIVE);
    localparam logic [PW-1:0] X_LAST  = PW'(H_ACTIVE - 1);
    localparam logic [PW-1:0] Y_LAST  = PW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    fbs_state_t    state, state_nxt;
    logic [PW-1:0] x, y;
    logic          sof, eof, accept, dark, frame_end, acc_init;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [PW-1:0] xmin_nxt, xmax_nxt, ymin_nxt, ymax_nxt;
    fbs_box_t      box_raw;
    logic          valid_raw;

    assign sof = iDVAL && !iRESYNC && (x == '0) && (y == '0);
    assign eof = iDVAL && !iRESYNC && (x == X_LAST) && (y == Y_LAST);

    // Raster position; runs on every valid pixel regardless of state.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            x <= '0;
            y <= '0;
        end else if (iRESYNC) begin
            x <= '0;
            y <= '0;
        end else if (iDVAL) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + PW'(1);
            end else begin
                x <= x + PW'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM next state; iEN only matters at frame boundaries.
    always_comb begin
        state_nxt = state;
        if (iRESYNC) begin
            state_nxt = WAIT_SOF;
        end else begin
            case (state)
                IDLE:     if (iEN) state_nxt = WAIT_SOF;
                WAIT_SOF: if (!iEN) state_nxt = IDLE;
                          else if (sof) state_nxt = ACQ;
                ACQ:      if (eof && !iEN) state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs: which pixels count, and when accumulators restart.
    always_comb begin
        accept    = !iRESYNC && iDVAL &&
                    ((state == ACQ) || ((state == WAIT_SOF) && iEN && sof));
        frame_end = accept && eof;
        dark      = accept && (iDATA < iTHRESH);
        acc_init  = iRESYNC || frame_end || ((state != ACQ) && !accept);
        oBUSY     = (state == ACQ);
    end

    fbs_minmax #(.W(PW), .INIT_MIN(X_LAST), .INIT_MAX('0)) u_xmm (
        .clk(iCLK), .rst(iRST), .init(acc_init), .update(dark), .value(x),
        .min_nxt(xmin_nxt), .max_nxt(xmax_nxt)
    );

    fbs_minmax #(.W(PW), .INIT_MIN(Y_LAST), .INIT_MAX('0)) u_ymm (
        .clk(iCLK), .rst(iRST), .init(acc_init), .update(dark), .value(y),
        .min_nxt(ymin_nxt), .max_nxt(ymax_nxt)
    );

    assign cnt_nxt = (dark && (cnt != CNT_MAX)) ? cnt + CW'(1) : cnt;

    // Saturating dark-pixel counter.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)          cnt <= '0;
        else if (acc_init) cnt <= '0;
        else               cnt <= cnt_nxt;
    end

    // Frame result including the current pixel; an empty frame reports zeros.
    always_comb begin
        box_raw = '0;
        if (cnt_nxt != '0) begin
            box_raw.xs = COORD_W'(xmin_nxt);
            box_raw.xe = COORD_W'(xmax_nxt);
            box_raw.ys = COORD_W'(ymin_nxt);
            box_raw.ye = COORD_W'(ymax_nxt);
        end
        valid_raw = (cnt_nxt >= CW'(MIN_COUNT));
    end

`ifdef FBS_MARGIN_EN
    fbs_box_t      p_box;
    logic [CW-1:0] p_cnt;
    logic          p_valid, p_pend;

    // First stage: capture the raw frame result.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            p_box   <= '0;
            p_cnt   <= '0;
            p_valid <= 1'b0;
            p_pend  <= 1'b0;
        end else begin
            p_pend <= frame_end;
            if (frame_end) begin
                p_box   <= box_raw;
                p_cnt   <= cnt_nxt;
                p_valid <= valid_raw;
            end
        end
    end

    // Second stage: expand by the margin, clamp, and publish.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oXSTART     <= '0;
            oXEND       <= '0;
            oYSTART     <= '0;
            oYEND       <= '0;
            oDARK_CNT   <= '0;
            oBOX_VALID  <= 1'b0;
            oFRAME_DONE <= 1'b0;
        end else begin
            oFRAME_DONE <= p_pend;
            if (p_pend) begin
                if (p_cnt != '0) begin
                    oXSTART <= fbs_expand_lo(p_box.xs, iMARGIN);
                    oXEND   <= fbs_expand_hi(p_box.xe, iMARGIN, COORD_W'(H_ACTIVE - 1));
                    oYSTART <= fbs_expand_lo(p_box.ys, iMARGIN);
                    oYEND   <= fbs_expand_hi(p_box.ye, iMARGIN, COORD_W'(V_ACTIVE - 1));
                end else begin
                    oXSTART <= '0;
                    oXEND   <= '0;
                    oYSTART <= '0;
                    oYEND   <= '0;
                end
                oDARK_CNT  <= p_cnt;
                oBOX_VALID <= p_valid;
            end
        end
    end
`else
    // Publish the frame result on the edge that takes the last pixel.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oXSTART     <= '0;
            oXEND       <= '0;
            oYSTART     <= '0;
            oYEND       <= '0;
            oDARK_CNT   <= '0;
            oBOX_VALID  <= 1'b0;
            oFRAME_DONE <= 1'b0;
        end else begin
            oFRAME_DONE <= frame_end;
            if (frame_end) begin
                oXSTART    <= box_raw.xs;
                oXEND      <= box_raw.xe;
                oYSTART    <= box_raw.ys;
                oYEND      <= box_raw.ye;
                oDARK_CNT  <= cnt_nxt;
                oBOX_VALID <= valid_raw;
            end
        end
    end
`endif

endmodule

// File: tb/tb_frame_bbox_stats.sv
// tb_frame_bbox_stats: table vectors, hand sequences and random frames
// checked against a whole-frame reference scan. Small frame geometry and a
// narrow counter keep run time short and make saturation reachable.
`timescale 1ns/1ps
module tb_frame_bbox_stats;

    localparam int DW   = 12;
    localparam int H    = 48;
    localparam int V    = 24;
    localparam int CW   = 8;
    localparam int MINC = 16;
`ifdef FBS_MARGIN_EN
    localparam int LAT  = 2;
`else
    localparam int LAT  = 1;
`endif

    logic          iCLK = 1'b0;
    logic          iRST, iEN, iDVAL, iRESYNC;
    logic [DW-1:0] iDATA, iTHRESH;
`ifdef FBS_MARGIN_EN
    logic [7:0]    margin;
`endif
    logic [15:0]   oXSTART, oXEND, oYSTART, oYEND;
    logic [CW-1:0] oDARK_CNT;
    logic          oBOX_VALID, oFRAME_DONE, oBUSY;

    frame_bbox_stats #(.DW(DW), .H_ACTIVE(H), .V_ACTIVE(V), .CW(CW), .MIN_COUNT(MINC)) dut (
        .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iDVAL(iDVAL), .iDATA(iDATA),
        .iTHRESH(iTHRESH), .iRESYNC(iRESYNC),
`ifdef FBS_MARGIN_EN
        .iMARGIN(margin),
`endif
        .oXSTART(oXSTART), .oXEND(oXEND), .oYSTART(oYSTART), .oYEND(oYEND),
        .oDARK_CNT(oDARK_CNT), .oBOX_VALID(oBOX_VALID),
        .oFRAME_DONE(oFRAME_DONE), .oBUSY(oBUSY)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int xs, xe, ys, ye, cnt, vld;
    } res_t;

    typedef struct {
        int x0, x1, y0, y1, dv, bv, t;
        int xs, xe, ys, ye, cnt, vld;
    } vec_t;

    logic [DW-1:0] img [V][H];
    logic [DW-1:0] thr [V][H];
    int tests = 0;
    int fails = 0;
    int pulses = 0;

    always @(negedge iCLK) if (oFRAME_DONE === 1'b1) pulses++;

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_res(input string tag, input res_t e);
        chk({tag, ".xs"},  int'(oXSTART),   e.xs);
        chk({tag, ".xe"},  int'(oXEND),     e.xe);
        chk({tag, ".ys"},  int'(oYSTART),   e.ys);
        chk({tag, ".ye"},  int'(oYEND),     e.ye);
        chk({tag, ".cnt"}, int'(oDARK_CNT), e.cnt);
        chk({tag, ".vld"}, int'(oBOX_VALID), e.vld);
    endtask

    task automatic fill_rect(input int x0, x1, y0, y1, dv, bv, t);
        for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++) begin
                img[yy][xx] = (xx >= x0 && xx <= x1 && yy >= y0 && yy <= y1) ? DW'(dv) : DW'(bv);
                thr[yy][xx] = DW'(t);
            end
    endtask

    // Reference: scan the stored frame, apply saturation, validity and margin.
    function automatic res_t model();
        res_t r;
        int n, x0, x1, y0, y1, sat;
        n = 0; x0 = H - 1; x1 = 0; y0 = V - 1; y1 = 0;
        sat = (1 << CW) - 1;
        for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++)
                if (img[yy][xx] < thr[yy][xx]) begin
                    n++;
                    if (xx < x0) x0 = xx;
                    if (xx > x1) x1 = xx;
                    if (yy < y0) y0 = yy;
                    if (yy > y1) y1 = yy;
                end
        r.cnt = (n > sat) ? sat : n;
        r.vld = (r.cnt >= MINC) ? 1 : 0;
        if (n == 0) begin
            r.xs = 0; r.xe = 0; r.ys = 0; r.ye = 0;
        end else begin
`ifdef FBS_MARGIN_EN
            x0 = (x0 - int'(margin) < 0) ? 0 : x0 - int'(margin);
            y0 = (y0 - int'(margin) < 0) ? 0 : y0 - int'(margin);
            x1 = (x1 + int'(margin) > H - 1) ? H - 1 : x1 + int'(margin);
            y1 = (y1 + int'(margin) > V - 1) ? V - 1 : y1 + int'(margin);
`endif
            r.xs = x0; r.xe = x1; r.ys = y0; r.ye = y1;
        end
        return r;
    endfunction

    // Drive n pixels in raster order starting at linear index first.
    task automatic send_px(input int first, input int n, input int gap);
        int idx, xx, yy;
        for (int i = 0; i < n; i++) begin
            idx = (first + i) % (H * V);
            xx = idx % H;
            yy = idx / H;
            if (gap > 0) begin
                repeat ($urandom_range(0, gap)) begin
                    iDVAL = 1'b0;
                    iDATA = DW'($urandom);
                    tick();
                end
            end
            iDVAL   = 1'b1;
            iDATA   = img[yy][xx];
            iTHRESH = thr[yy][xx];
            tick();
        end
        iDVAL = 1'b0;
    endtask

    // Full frame from (0,0); expects exactly one done pulse after LAT cycles.
    task automatic run_frame(input string tag, input res_t e, input int gap);
        int p0;
        p0 = pulses;
        send_px(0, H * V, gap);
        repeat (LAT - 1) tick();
        chk({tag, ".done"}, int'(oFRAME_DONE), 1);
        chk_res(tag, e);
        tick();
        chk({tag, ".done_low"}, int'(oFRAME_DONE), 0);
        chk({tag, ".pulses"}, pulses, p0 + 1);
    endtask

    function automatic res_t vexp(input vec_t v);
        res_t r;
        r.xs = v.xs; r.xe = v.xe; r.ys = v.ys; r.ye = v.ye; r.cnt = v.cnt; r.vld = v.vld;
        return r;
    endfunction

    initial begin
        vec_t vecs[6];
        res_t e, held;
        int p0;
        int thrmax[8];

        //            x0  x1  y0  y1  dv    bv    t     xs xe  ys ye  cnt vld
        vecs[0] = '{ -1, -1, -1, -1, 0,    4095, 2048, 0, 0,  0, 0,  0,   0};
        vecs[1] = '{ 10, 19, 5,  14, 0,    4095, 2048, 10, 19, 5, 14, 100, 1};
        vecs[2] = '{ 47, 47, 23, 23, 0,    4095, 2048, 47, 47, 23, 23, 1,  0};
        vecs[3] = '{ 3,  6,  2,  5,  2047, 2048, 2048, 3, 6,  2, 5,  16,  1};
        vecs[4] = '{ 0,  4,  0,  2,  0,    4095, 2048, 0, 4,  0, 2,  15,  0};
        vecs[5] = '{ 0,  47, 0,  23, 0,    4095, 2048, 0, 47, 0, 23, 255, 1};
        thrmax = '{0, 40, 100, 250, 600, 4095, 60, 150};

        iRST = 1'b1; iEN = 1'b0; iDVAL = 1'b0; iRESYNC = 1'b0;
        iDATA = '0; iTHRESH = '0;
`ifdef FBS_MARGIN_EN
        margin = 8'd0;
`endif
        repeat (3) tick();
        e = '{0, 0, 0, 0, 0, 0};
        chk_res("reset", e);
        chk("reset.done", int'(oFRAME_DONE), 0);
        chk("reset.busy", int'(oBUSY), 0);
        iRST = 1'b0;
        iEN  = 1'b1;
        tick();

        // Table vectors, back to back.
        for (int i = 0; i < 6; i++) begin
            fill_rect(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1,
                      vecs[i].dv, vecs[i].bv, vecs[i].t);
            run_frame($sformatf("vec%0d", i), vexp(vecs[i]), (i % 2) * 3);
        end

        // iEN dropped mid-frame: frame still reports, then idle.
        fill_rect(10, 19, 5, 14, 0, 4095, 2048);
        p0 = pulses;
        send_px(0, (H * V) / 2, 1);
        chk("endrop.busy_mid", int'(oBUSY), 1);
        iEN = 1'b0;
        send_px((H * V) / 2, (H * V) / 2, 1);
        repeat (LAT - 1) tick();
        chk("endrop.done", int'(oFRAME_DONE), 1);
        chk_res("endrop", vexp(vecs[1]));
        tick();
        chk("endrop.busy_after", int'(oBUSY), 0);
        chk("endrop.pulses", pulses, p0 + 1);

        // iEN low for a whole frame: nothing reported, outputs held.
        fill_rect(0, 4, 0, 2, 0, 4095, 2048);
        p0 = pulses;
        send_px(0, H * V, 0);
        repeat (3) tick();
        chk("endis.pulses", pulses, p0);
        chk_res("endis.hold", vexp(vecs[1]));

        // iEN raised mid-frame: partial frame ignored, next full frame reports.
        p0 = pulses;
        send_px(0, (H * V) / 2, 0);
        iEN = 1'b1;
        send_px((H * V) / 2, (H * V) / 2, 0);
        repeat (3) tick();
        chk("enrise.partial_pulses", pulses, p0);
        fill_rect(47, 47, 23, 23, 0, 4095, 2048);
        run_frame("enrise.full", vexp(vecs[2]), 0);

        // Reset mid-frame at (24,12): outputs clear at once, no pulse.
        fill_rect(10, 19, 5, 14, 0, 4095, 2048);
        p0 = pulses;
        send_px(0, H * (V / 2) + H / 2, 0);
        iRST = 1'b1;
        #1;
        chk("rstmid.xs", int'(oXSTART), 0);
        chk("rstmid.ye", int'(oYEND), 0);
        chk("rstmid.cnt", int'(oDARK_CNT), 0);
        chk("rstmid.busy", int'(oBUSY), 0);
        tick();
        iRST = 1'b0;
        repeat (3) tick();
        chk("rstmid.pulses", pulses, p0);
        run_frame("rstmid.next", vexp(vecs[1]), 0);

        // Resync mid-frame, asserted alongside a dark valid pixel.
        held = vexp(vecs[1]);
        fill_rect(0, 4, 0, 2, 0, 4095, 2048);
        p0 = pulses;
        send_px(0, 300, 0);
        iDVAL = 1'b1; iDATA = '0; iTHRESH = 12'd2048; iRESYNC = 1'b1;
        tick();
        iDVAL = 1'b0; iRESYNC = 1'b0;
        repeat (2) tick();
        chk("resync.pulses", pulses, p0);
        chk_res("resync.hold", held);
        run_frame("resync.next", vexp(vecs[4]), 0);

`ifdef FBS_MARGIN_EN
        // Margin expansion clamped at every frame edge.
        margin = 8'd10;
        fill_rect(5, 44, 2, 20, 0, 4095, 2048);
        e = '{0, 47, 0, 23, 255, 1};
        run_frame("margin.clamp", e, 0);
`endif

        // Random pixels and per-pixel thresholds against the reference scan.
        for (int k = 0; k < 8; k++) begin
            for (int yy = 0; yy < V; yy++)
                for (int xx = 0; xx < H; xx++) begin
                    img[yy][xx] = DW'($urandom_range(0, 4095));
                    thr[yy][xx] = DW'($urandom_range(0, thrmax[k]));
                end
`ifdef FBS_MARGIN_EN
            margin = 8'($urandom_range(0, 15));
`endif
            e = model();
            run_frame($sformatf("rand%0d", k), e, k % 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
